// File: rtl/calc_req_scheduler.sv
// Round-robin front end for one calc2_top port: grant -> cmd/op1 at T+1, op2 at T+2; response -> rs_* at +1.
// rq_ready holds low while the command bus is busy (CMD) or all four calculator tags are outstanding.
module calc_req_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      c_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        rq_valid,
  output logic [NUM_REQ-1:0]        rq_ready,
  input  logic [4*NUM_REQ-1:0]      rq_cmd,
  input  logic [DATA_W*NUM_REQ-1:0] rq_op1,
  input  logic [DATA_W*NUM_REQ-1:0] rq_op2,
  input  logic [2*NUM_REQ-1:0]      rq_tag,
  output logic [NUM_REQ-1:0]        rs_valid,
  output logic [1:0]                rs_resp,
  output logic [DATA_W-1:0]         rs_data,
  output logic [1:0]                rs_tag,
  output logic [3:0]                req_cmd_out,
  output logic [DATA_W-1:0]         req_data_out,
  output logic [1:0]                req_tag_out,
  input  logic [1:0]                out_resp,
  input  logic [DATA_W-1:0]         out_data,
  input  logic [1:0]                out_tag,
  output logic                      busy,
  output logic [2:0]                tags_free,
  output logic                      err_spurious
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_OPND} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_rr_ptr;
  logic [3:0]          r_tv;
  logic [1:0]          r_tid  [4];
  logic [1:0]          r_ttag [4];
  logic [3:0]          r_cmd;
  logic [DATA_W-1:0]   r_op1, r_op2;
  logic [1:0]          r_tag;
  logic [NUM_REQ-1:0]  r_rs_valid;
  logic [1:0]          r_rs_resp, r_rs_tag;
  logic [DATA_W-1:0]   r_rs_data;
  logic                r_err;
  logic [2:0]          r_tags_free;

  logic                w_found, w_free_any, w_grant, w_alloc, w_resp_hit;
  logic [1:0]          w_winner, w_free_tag, w_rr_nxt, w_win_tag;
  logic [3:0]          w_win_cmd, w_vld_nxt;
  logic [DATA_W-1:0]   w_win_op1, w_win_op2;
  logic [2:0]          w_cnt;
  int                  w_dist, w_best;

  // Winner is the valid requester at the smallest rotational distance from r_rr_ptr.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = 2'd0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    w_win_cmd = '0;
    w_win_op1 = '0;
    w_win_op2 = '0;
    w_win_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
      if (rq_valid[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_found   = 1'b1;
        w_winner  = 2'(i);
        w_win_cmd = rq_cmd[4*i +: 4];
        w_win_op1 = rq_op1[DATA_W*i +: DATA_W];
        w_win_op2 = rq_op2[DATA_W*i +: DATA_W];
        w_win_tag = rq_tag[2*i +: 2];
      end
    end
  end

  always_comb begin
    w_free_any = 1'b0;
    w_free_tag = 2'd0;
    for (int t = 3; t >= 0; t--) begin
      if (!r_tv[t]) begin
        w_free_any = 1'b1;
        w_free_tag = 2'(t);
      end
    end
  end

  assign w_grant    = reset_n && (r_state != S_CMD) && w_found && w_free_any;
  assign w_alloc    = w_grant && (w_win_cmd != 4'd0);
  assign w_resp_hit = (out_resp != 2'd0) && r_tv[out_tag];
  assign w_rr_nxt   = (int'(w_winner) == NUM_REQ-1) ? 2'd0 : w_winner + 2'd1;

  always_comb begin
    rq_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) rq_ready[i] = w_grant && (w_winner == 2'(i));
  end

  // Allocation only ever picks a currently-free entry, so it never collides with the entry being freed.
  always_comb begin
    w_vld_nxt = r_tv;
    if (w_alloc)    w_vld_nxt[w_free_tag] = 1'b1;
    if (w_resp_hit) w_vld_nxt[out_tag]    = 1'b0;
    w_cnt = 3'd0;
    for (int t = 0; t < 4; t++) w_cnt = w_cnt + {2'b00, w_vld_nxt[t]};
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_cmd_out  = 4'd0;
    req_data_out = '0;
    req_tag_out  = 2'd0;
    case (r_state)
      S_IDLE: if (w_alloc) w_state_nxt = S_CMD;
      S_CMD: begin
        req_cmd_out  = r_cmd;
        req_data_out = r_op1;
        req_tag_out  = r_tag;
        w_state_nxt  = S_OPND;
      end
      S_OPND: begin
        req_data_out = r_op2;
        req_tag_out  = r_tag;
        w_state_nxt  = w_alloc ? S_CMD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 2'd0;
      r_tv        <= 4'd0;
      r_cmd       <= 4'd0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_tag       <= 2'd0;
      r_rs_valid  <= '0;
      r_rs_resp   <= 2'd0;
      r_rs_data   <= '0;
      r_rs_tag    <= 2'd0;
      r_err       <= 1'b0;
      r_tags_free <= 3'd4;
      for (int t = 0; t < 4; t++) begin
        r_tid[t]  <= 2'd0;
        r_ttag[t] <= 2'd0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_tv        <= w_vld_nxt;
      r_tags_free <= 3'd4 - w_cnt;
      if (w_grant) r_rr_ptr <= w_rr_nxt;
      if (w_alloc) begin
        r_cmd              <= w_win_cmd;
        r_op1              <= w_win_op1;
        r_op2              <= w_win_op2;
        r_tag              <= w_free_tag;
        r_tid[w_free_tag]  <= w_winner;
        r_ttag[w_free_tag] <= w_win_tag;
      end
      r_rs_valid <= '0;
      if (w_resp_hit) begin
        for (int i = 0; i < NUM_REQ; i++) r_rs_valid[i] <= (r_tid[out_tag] == 2'(i));
        r_rs_resp <= out_resp;
        r_rs_data <= out_data;
        r_rs_tag  <= r_ttag[out_tag];
      end else if (out_resp != 2'd0) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rs_valid     = r_rs_valid;
  assign rs_resp      = r_rs_resp;
  assign rs_data      = r_rs_data;
  assign rs_tag       = r_rs_tag;
  assign tags_free    = r_tags_free;
  assign err_spurious = r_err;
  assign busy         = (r_tv != 4'd0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_calc_req_scheduler.sv
// Directed and random stimulus for calc_req_scheduler against a cycle-timeline reference model.
module tb_calc_req_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;

  logic              c_clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      rq_valid, rq_ready, rs_valid;
  logic [4*N-1:0]    rq_cmd;
  logic [DW*N-1:0]   rq_op1, rq_op2;
  logic [2*N-1:0]    rq_tag;
  logic [1:0]        rs_resp, rs_tag, req_tag_out, out_resp, out_tag;
  logic [DW-1:0]     rs_data, req_data_out, out_data;
  logic [3:0]        req_cmd_out;
  logic              busy, err_spurious;
  logic [2:0]        tags_free;

  always #5 c_clk = ~c_clk;

  calc_req_scheduler #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_cmd(rq_cmd),
    .rq_op1(rq_op1), .rq_op2(rq_op2), .rq_tag(rq_tag),
    .rs_valid(rs_valid), .rs_resp(rs_resp), .rs_data(rs_data), .rs_tag(rs_tag),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .tags_free(tags_free), .err_spurious(err_spurious)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Requester-side pending requests (held until accepted).
  bit          p_vld [N];
  logic [3:0]  p_cmd [N];
  logic [DW-1:0] p_op1 [N], p_op2 [N];
  logic [1:0]  p_tag [N];

  // Reference model: tag pool plus expected-by-cycle timelines.
  int  m_ptr, m_next_arb;
  bit  m_tv [4];
  int  m_tid [4], m_ttag [4];
  bit  m_err;
  int  e_bcmd [int], e_btag [int];
  logic [DW-1:0] e_bdat [int];
  int  e_rsv [int], e_rsr [int], e_rst [int];
  logic [DW-1:0] e_rsd [int];
  int  g_win;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", nm, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      rq_valid[i]          = p_vld[i];
      rq_cmd[4*i +: 4]     = p_cmd[i];
      rq_op1[DW*i +: DW]   = p_op1[i];
      rq_op2[DW*i +: DW]   = p_op2[i];
      rq_tag[2*i +: 2]     = p_tag[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_next_arb = 0; m_err = 0;
    for (int t = 0; t < 4; t++) m_tv[t] = 0;
    e_bcmd.delete(); e_btag.delete(); e_bdat.delete();
    e_rsv.delete(); e_rsr.delete(); e_rst.delete(); e_rsd.delete();
  endtask

  // One clock: drive at negedge, check everything, advance the model across the posedge.
  task automatic cycle();
    int free, win, t;
    bit hit;
    logic [3:0] er;
    drive();
    #1;
    free = 0;
    for (int k = 0; k < 4; k++) if (!m_tv[k]) free++;
    win = -1;
    if (reset_n && cyc >= m_next_arb && free > 0)
      for (int k = N-1; k >= 0; k--) if (p_vld[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    er = (win >= 0) ? 4'(1 << win) : 4'd0;
    chk("rq_ready", rq_ready, er);
    if (e_bcmd.exists(cyc)) begin
      chk("bus_cmd", req_cmd_out, e_bcmd[cyc]);
      chk("bus_data", req_data_out, e_bdat[cyc]);
      chk("bus_tag", req_tag_out, e_btag[cyc]);
    end else begin
      chk("bus_cmd_idle", req_cmd_out, 0);
      chk("bus_data_idle", req_data_out, 0);
      chk("bus_tag_idle", req_tag_out, 0);
    end
    if (e_rsv.exists(cyc)) begin
      chk("rs_valid", rs_valid, e_rsv[cyc]);
      chk("rs_resp", rs_resp, e_rsr[cyc]);
      chk("rs_data", rs_data, e_rsd[cyc]);
      chk("rs_tag", rs_tag, e_rst[cyc]);
    end else begin
      chk("rs_valid_idle", rs_valid, 0);
    end
    chk("tags_free", tags_free, free);
    chk("busy", busy, (free < 4) || e_bcmd.exists(cyc));
    chk("err_spurious", err_spurious, m_err);
    g_win = win;
    if (!reset_n) begin
      model_reset();
    end else begin
      hit = (out_resp != 0) && m_tv[out_tag];
      if (out_resp != 0 && !hit) m_err = 1;
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        if (p_cmd[win] != 0) begin
          t = 0;
          while (m_tv[t]) t++;
          m_tv[t] = 1; m_tid[t] = win; m_ttag[t] = p_tag[win];
          e_bcmd[cyc+1] = p_cmd[win]; e_bdat[cyc+1] = p_op1[win]; e_btag[cyc+1] = t;
          e_bcmd[cyc+2] = 0;          e_bdat[cyc+2] = p_op2[win]; e_btag[cyc+2] = t;
          m_next_arb = cyc + 2;
        end
        p_vld[win] = 0;
      end
      if (hit) begin
        e_rsv[cyc+1] = 1 << m_tid[out_tag];
        e_rsr[cyc+1] = out_resp;
        e_rsd[cyc+1] = out_data;
        e_rst[cyc+1] = m_ttag[out_tag];
        m_tv[out_tag] = 0;
      end
    end
    @(posedge c_clk);
    cyc++;
    @(negedge c_clk);
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [1:0] tg);
    p_vld[i] = 1; p_cmd[i] = c; p_op1[i] = a; p_op2[i] = b; p_tag[i] = tg;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) p_vld[i] = 0;
    for (int k = 0; k < 16; k++) begin
      out_resp = 0;
      for (int t = 0; t < 4; t++)
        if (m_tv[t]) begin out_resp = 2'd1; out_tag = 2'(t); out_data = $urandom; end
      cycle();
    end
    out_resp = 0;
  endtask

  logic [3:0] rec_cmd [4];
  logic [1:0] rec_tag [4];
  int nrec;

  initial begin
    reset_n = 1'b0;
    out_resp = 0; out_data = 0; out_tag = 0;
    for (int i = 0; i < N; i++) begin
      p_vld[i] = 0; p_cmd[i] = 0; p_op1[i] = 0; p_op2[i] = 0; p_tag[i] = 0;
    end
    drive();
    repeat (2) @(posedge c_clk);
    @(negedge c_clk);
    model_reset();
    cycle();
    reset_n = 1'b1;
    chk("rst_rs_resp", rs_resp, 0);
    chk("rst_rs_data", rs_data, 0);
    chk("rst_rs_tag", rs_tag, 0);
    chk("rst_tags_free", tags_free, 4);

    // Single request from requester 1.
    set_req(1, 4'd1, 32'd5, 32'd7, 2'd2);
    drive(); #1;
    chk("t1_ready", rq_ready, 4'b0010);
    cycle();
    chk("t1_cmd", req_cmd_out, 1);
    chk("t1_op1", req_data_out, 5);
    chk("t1_tag", req_tag_out, 0);
    cycle();
    chk("t1_cmd2", req_cmd_out, 0);
    chk("t1_op2", req_data_out, 7);
    out_resp = 2'd1; out_data = 32'd12; out_tag = 2'd0;
    cycle();
    out_resp = 0;
    chk("t1_rs_valid", rs_valid, 4'b0010);
    chk("t1_rs_data", rs_data, 12);
    chk("t1_rs_tag", rs_tag, 2);
    chk("t1_tags_free", tags_free, 4);

    // All four requesters valid: order 0..3, tags 0..3, then tags exhausted.
    reset_dut();
    for (int i = 0; i < N; i++) set_req(i, 4'(i+1), 32'(100+i), 32'(200+i), 2'(3-i));
    nrec = 0;
    for (int k = 0; k < 4; k++) begin rec_cmd[k] = 4'hF; rec_tag[k] = 2'bxx; end
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (req_cmd_out != 0 && nrec < 4) begin
        rec_cmd[nrec] = req_cmd_out; rec_tag[nrec] = req_tag_out; nrec++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", rec_cmd[k], k+1);
      chk("t2_tag", rec_tag[k], k);
    end
    for (int i = 0; i < N; i++) set_req(i, 4'(i+5), 32'(300+i), 32'(400+i), 2'(i));
    drive(); #1;
    chk("t2_full_ready", rq_ready, 0);
    chk("t2_full_free", tags_free, 0);
    cycle(); cycle();

    // Return tag 2 while full: next grant reuses it.
    out_resp = 2'd2; out_data = 32'hAB; out_tag = 2'd2;
    cycle();
    out_resp = 0;
    chk("t3_rs_valid", rs_valid, 4'b0100);
    chk("t3_rs_tag", rs_tag, 1);
    chk("t3_rs_resp", rs_resp, 2);
    drive(); #1;
    chk("t3_ready", rq_ready, 4'b0001);
    cycle();
    chk("t3_reuse_tag", req_tag_out, 2);
    chk("t3_reuse_cmd", req_cmd_out, 5);

    // Out-of-order responses, tag 0 returned in the same cycle as a grant.
    out_resp = 2'd1; out_data = 32'h33; out_tag = 2'd3;
    cycle();
    out_resp = 2'd3; out_data = 32'h44; out_tag = 2'd0;
    drive(); #1;
    chk("t4_ready", rq_ready, 4'b0010);
    chk("t4_rs3_valid", rs_valid, 4'b1000);
    chk("t4_rs3_tag", rs_tag, 0);
    cycle();
    out_resp = 0;
    chk("t4_rs0_valid", rs_valid, 4'b0001);
    chk("t4_rs0_tag", rs_tag, 3);
    chk("t4_rs0_resp", rs_resp, 3);
    chk("t4_grant_cmd", req_cmd_out, 6);
    chk("t4_grant_tag", req_tag_out, 3);
    drain();
    chk("t4_drained", tags_free, 4);

    // Spurious response is sticky until reset.
    reset_dut();
    out_resp = 2'd1; out_tag = 2'd1; out_data = 32'h55;
    cycle();
    out_resp = 0;
    chk("t5_no_rs", rs_valid, 0);
    chk("t5_err", err_spurious, 1);
    cycle(); cycle();
    chk("t5_err_sticky", err_spurious, 1);
    reset_dut();
    chk("t5_err_clr", err_spurious, 0);

    // Reset during OPND, then a late response for the aborted tag.
    set_req(0, 4'd3, 32'd9, 32'd10, 2'd1);
    cycle(); cycle();
    chk("t6_opnd", req_data_out, 10);
    reset_dut();
    chk("t6_cmd", req_cmd_out, 0);
    chk("t6_data", req_data_out, 0);
    chk("t6_free", tags_free, 4);
    chk("t6_busy", busy, 0);
    out_resp = 2'd1; out_tag = 2'd0;
    cycle();
    out_resp = 0;
    chk("t6_late_err", err_spurious, 1);

    // Random traffic.
    reset_dut();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if (!p_vld[i] && $urandom_range(0, 3) == 0)
          set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom, 2'($urandom_range(0, 3)));
      out_resp = 0;
      if ($urandom_range(0, 2) == 0) begin
        int t;
        t = $urandom_range(0, 3);
        if (m_tv[t]) begin
          out_resp = 2'($urandom_range(1, 3)); out_tag = 2'(t); out_data = $urandom;
        end
      end
      cycle();
    end
    drain();
    chk("rand_drained", tags_free, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
